// File: rtl/phy_link_ctrl.sv
// rtl/phy_link_ctrl.sv - PCS passthrough with controlled link-down / restore sequencing
module phy_link_ctrl #(
  parameter int g_drain_timeout = 4096,
  parameter int g_hold_width    = 16
) (
  input  logic                    clk_ref_i,
  input  logic                    rst_i,
  input  logic [15:0]             tx_data_i,
  input  logic [1:0]              tx_k_i,
  output logic [15:0]             rx_data_o,
  output logic [1:0]              rx_k_o,
  input  logic                    link_down_req_i,
  input  logic                    link_up_req_i,
  input  logic                    auto_up_i,
  input  logic [g_hold_width-1:0] hold_cycles_i,
  output logic                    link_up_o,
  output logic                    busy_o,
  output logic [g_hold_width-1:0] down_cnt_o,
  output logic                    req_ignored_o,
  output logic                    drain_tmo_o
);

  // Drain counter spans 0 .. g_drain_timeout-1; the last value marks the final DRAIN cycle.
  localparam int                    DW         = $clog2(g_drain_timeout + 1);
  localparam logic [DW-1:0]         DRAIN_LAST = DW'(g_drain_timeout - 1);
  localparam logic [DW-1:0]         DRAIN_ONE  = DW'(1);
  localparam logic [g_hold_width-1:0] HOLD_ONE = g_hold_width'(1);
  localparam logic [15:0]           IDLE_DATA  = 16'h00BC;
  localparam logic [1:0]            IDLE_K     = 2'b01;

  typedef enum logic [2:0] {
    ST_UP,
    ST_DRAIN,
    ST_DOWN,
    ST_WAIT_UP,
    ST_RESTORE
  } state_t;

  state_t                  state;
  logic [DW-1:0]           drain_cnt;
  logic [g_hold_width-1:0] hold_cnt;
  logic [g_hold_width-1:0] hold_lat;
  logic                    auto_lat;
  logic                    tx_idle;
  logic                    drain_done;

  assign tx_idle    = (tx_k_i == IDLE_K) && (tx_data_i[7:0] == 8'hBC);
  assign drain_done = tx_idle || (drain_cnt == DRAIN_LAST);

  // Link sequencer: state, datapath mux and all status outputs are registered together.
  always_ff @(posedge clk_ref_i) begin
    if (rst_i) begin
      state         <= ST_UP;
      rx_data_o     <= IDLE_DATA;
      rx_k_o        <= IDLE_K;
      link_up_o     <= 1'b1;
      busy_o        <= 1'b0;
      down_cnt_o    <= '0;
      req_ignored_o <= 1'b0;
      drain_tmo_o   <= 1'b0;
      drain_cnt     <= '0;
      hold_cnt      <= '0;
      hold_lat      <= '0;
      auto_lat      <= 1'b0;
    end else begin
      req_ignored_o <= 1'b0;
      drain_tmo_o   <= 1'b0;
      case (state)
        ST_UP: begin
          rx_data_o <= tx_data_i;
          rx_k_o    <= tx_k_i;
          if (link_up_req_i) req_ignored_o <= 1'b1;
          if (link_down_req_i) begin
            hold_lat  <= hold_cycles_i;
            auto_lat  <= auto_up_i;
            drain_cnt <= '0;
            state     <= ST_DRAIN;
            busy_o    <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (link_down_req_i || link_up_req_i) req_ignored_o <= 1'b1;
          if (drain_done) begin
            // Cut over on the idle boundary, or forcibly (mid-frame) once the budget is spent.
            rx_data_o   <= IDLE_DATA;
            rx_k_o      <= IDLE_K;
            drain_tmo_o <= ~tx_idle;
            state       <= ST_DOWN;
            hold_cnt    <= hold_lat;
            link_up_o   <= 1'b0;
            if (down_cnt_o != '1) down_cnt_o <= down_cnt_o + HOLD_ONE;
          end else begin
            rx_data_o <= tx_data_i;
            rx_k_o    <= tx_k_i;
            drain_cnt <= drain_cnt + DRAIN_ONE;
          end
        end
        ST_DOWN: begin
          rx_data_o <= IDLE_DATA;
          rx_k_o    <= IDLE_K;
          if (link_down_req_i || link_up_req_i) req_ignored_o <= 1'b1;
          // Zero is checked before decrementing so a hold of N gives N+1 DOWN cycles.
          if (hold_cnt == '0) begin
            state <= auto_lat ? ST_RESTORE : ST_WAIT_UP;
          end else begin
            hold_cnt <= hold_cnt - HOLD_ONE;
          end
        end
        ST_WAIT_UP: begin
          rx_data_o <= IDLE_DATA;
          rx_k_o    <= IDLE_K;
          if (link_down_req_i) req_ignored_o <= 1'b1;
          if (link_up_req_i) state <= ST_RESTORE;
        end
        ST_RESTORE: begin
          if (link_down_req_i || link_up_req_i) req_ignored_o <= 1'b1;
          if (tx_idle) begin
            // Reopen on an idle word so the switch port never sees a partial frame.
            rx_data_o <= tx_data_i;
            rx_k_o    <= tx_k_i;
            link_up_o <= 1'b1;
            busy_o    <= 1'b0;
            state     <= ST_UP;
          end else begin
            rx_data_o <= IDLE_DATA;
            rx_k_o    <= IDLE_K;
          end
        end
        default: begin
          state     <= ST_UP;
          busy_o    <= 1'b0;
          link_up_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phy_link_ctrl.sv
// tb/tb_phy_link_ctrl.sv - self-checking bench for phy_link_ctrl
module tb_phy_link_ctrl;

  localparam int TMO  = 16;
  localparam int HW   = 4;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   tx_data;
  logic [1:0]    tx_k;
  logic [15:0]   rx_data;
  logic [1:0]    rx_k;
  logic          down, up, auto;
  logic [HW-1:0] hold;
  logic          link_up, busy, ign, tmo;
  logic [HW-1:0] down_cnt;

  int checks = 0;
  int errors = 0;

  phy_link_ctrl #(.g_drain_timeout(TMO), .g_hold_width(HW)) dut (
    .clk_ref_i(clk), .rst_i(rst), .tx_data_i(tx_data), .tx_k_i(tx_k),
    .rx_data_o(rx_data), .rx_k_o(rx_k), .link_down_req_i(down), .link_up_req_i(up),
    .auto_up_i(auto), .hold_cycles_i(hold), .link_up_o(link_up), .busy_o(busy),
    .down_cnt_o(down_cnt), .req_ignored_o(ign), .drain_tmo_o(tmo)
  );

  always #5 clk = ~clk;

  // Reference model: link phases with "cycles remaining" bookkeeping.
  localparam int P_LIVE = 0, P_FLUSH = 1, P_QUIET = 2, P_PARK = 3, P_WAKE = 4;
  int          m_phase, m_age, m_quiet, m_hold, m_cnt;
  logic        m_auto, m_link, m_ign, m_tmo;
  logic [15:0] m_data;
  logic [1:0]  m_k;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    logic idle;
    idle = (tx_k == 2'b01) && (tx_data[7:0] == 8'hBC);
    if (rst) begin
      m_phase = P_LIVE; m_data = 16'h00BC; m_k = 2'b01; m_link = 1'b1;
      m_cnt = 0; m_ign = 1'b0; m_tmo = 1'b0; m_age = 0; m_quiet = 0;
    end else begin
      m_ign = (down && m_phase != P_LIVE) || (up && m_phase != P_PARK);
      m_tmo = 1'b0;
      case (m_phase)
        P_LIVE: begin
          m_data = tx_data; m_k = tx_k;
          if (down) begin m_hold = int'(hold); m_auto = auto; m_age = 0; m_phase = P_FLUSH; end
        end
        P_FLUSH: begin
          m_age++;
          if (idle || m_age == TMO) begin
            m_data = 16'h00BC; m_k = 2'b01; m_tmo = !idle;
            m_phase = P_QUIET; m_quiet = m_hold + 1; m_link = 1'b0;
            if (m_cnt < CMAX) m_cnt++;
          end else begin
            m_data = tx_data; m_k = tx_k;
          end
        end
        P_QUIET: begin
          m_data = 16'h00BC; m_k = 2'b01;
          m_quiet--;
          if (m_quiet == 0) m_phase = m_auto ? P_WAKE : P_PARK;
        end
        P_PARK: begin
          m_data = 16'h00BC; m_k = 2'b01;
          if (up) m_phase = P_WAKE;
        end
        default: begin
          if (idle) begin
            m_data = tx_data; m_k = tx_k; m_link = 1'b1; m_phase = P_LIVE;
          end else begin
            m_data = 16'h00BC; m_k = 2'b01;
          end
        end
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("model_rx_data", 32'(rx_data), 32'(m_data));
    chk("model_rx_k", 32'(rx_k), 32'(m_k));
    chk("model_link_up", 32'(link_up), 32'(m_link));
    chk("model_busy", 32'(busy), 32'(m_phase != P_LIVE));
    chk("model_down_cnt", 32'(down_cnt), 32'(m_cnt));
    chk("model_req_ignored", 32'(ign), 32'(m_ign));
    chk("model_drain_tmo", 32'(tmo), 32'(m_tmo));
  endtask

  task automatic set_idle();
    tx_data = 16'h00BC; tx_k = 2'b01;
  endtask

  task automatic req_down(input logic a, input logic [HW-1:0] h);
    down = 1'b1; auto = a; hold = h;
    tick();
    down = 1'b0; auto = 1'b0; hold = '0;
  endtask

  typedef struct {
    logic rst; logic [15:0] d; logic [1:0] k; logic dn; logic up; logic au; logic [HW-1:0] h;
    logic [15:0] ed; logic [1:0] ek; logic el; logic eb; logic [HW-1:0] ec; logic ei;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [15:0] d, input logic [1:0] k,
                              input logic dn, input logic u, input logic au, input logic [HW-1:0] h,
                              input logic [15:0] ed, input logic [1:0] ek, input logic el,
                              input logic eb, input logic [HW-1:0] ec, input logic ei);
    vec_t v;
    v.rst = r; v.d = d; v.k = k; v.dn = dn; v.up = u; v.au = au; v.h = h;
    v.ed = ed; v.ek = ek; v.el = el; v.eb = eb; v.ec = ec; v.ei = ei;
    return v;
  endfunction

  vec_t vt[13];

  initial begin
    int n_low, n_drain, n_tmo, n_high;
    logic [15:0] first_d;
    logic [1:0]  first_k;

    rst = 1'b1; tx_data = 16'h1234; tx_k = 2'b00; down = 1'b0; up = 1'b0; auto = 1'b0; hold = '0;

    //          rst   data      k      dn    up    au    h      exp data  k      lnk   busy  cnt    ign
    vt[0]  = mk(1'b1, 16'h1234, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0, 16'h00BC, 2'b01, 1'b1, 1'b0, 4'd0, 1'b0);
    vt[1]  = mk(1'b0, 16'hA5A5, 2'b00, 1'b0, 1'b1, 1'b0, 4'd0, 16'hA5A5, 2'b00, 1'b1, 1'b0, 4'd0, 1'b1);
    vt[2]  = mk(1'b0, 16'h5A5A, 2'b11, 1'b0, 1'b0, 1'b0, 4'd0, 16'h5A5A, 2'b11, 1'b1, 1'b0, 4'd0, 1'b0);
    vt[3]  = mk(1'b0, 16'h12BC, 2'b01, 1'b0, 1'b0, 1'b0, 4'd0, 16'h12BC, 2'b01, 1'b1, 1'b0, 4'd0, 1'b0);
    vt[4]  = mk(1'b0, 16'h3333, 2'b00, 1'b1, 1'b0, 1'b1, 4'd2, 16'h3333, 2'b00, 1'b1, 1'b1, 4'd0, 1'b0);
    vt[5]  = mk(1'b0, 16'h4444, 2'b10, 1'b1, 1'b0, 1'b0, 4'd0, 16'h4444, 2'b10, 1'b1, 1'b1, 4'd0, 1'b1);
    vt[6]  = mk(1'b0, 16'h77BC, 2'b01, 1'b0, 1'b0, 1'b0, 4'd0, 16'h00BC, 2'b01, 1'b0, 1'b1, 4'd1, 1'b0);
    vt[7]  = mk(1'b0, 16'h8888, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0, 16'h00BC, 2'b01, 1'b0, 1'b1, 4'd1, 1'b0);
    vt[8]  = mk(1'b0, 16'h8888, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0, 16'h00BC, 2'b01, 1'b0, 1'b1, 4'd1, 1'b0);
    vt[9]  = mk(1'b0, 16'h8888, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0, 16'h00BC, 2'b01, 1'b0, 1'b1, 4'd1, 1'b0);
    vt[10] = mk(1'b0, 16'h9999, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0, 16'h00BC, 2'b01, 1'b0, 1'b1, 4'd1, 1'b0);
    vt[11] = mk(1'b0, 16'hABBC, 2'b01, 1'b0, 1'b0, 1'b0, 4'd0, 16'hABBC, 2'b01, 1'b1, 1'b0, 4'd1, 1'b0);
    vt[12] = mk(1'b0, 16'h1111, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0, 16'h1111, 2'b00, 1'b1, 1'b0, 4'd1, 1'b0);

    foreach (vt[i]) begin
      rst = vt[i].rst; tx_data = vt[i].d; tx_k = vt[i].k;
      down = vt[i].dn; up = vt[i].up; auto = vt[i].au; hold = vt[i].h;
      tick();
      chk($sformatf("vec%0d_rx_data", i), 32'(rx_data), 32'(vt[i].ed));
      chk($sformatf("vec%0d_rx_k", i), 32'(rx_k), 32'(vt[i].ek));
      chk($sformatf("vec%0d_link_up", i), 32'(link_up), 32'(vt[i].el));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].eb));
      chk($sformatf("vec%0d_down_cnt", i), 32'(down_cnt), 32'(vt[i].ec));
      chk($sformatf("vec%0d_req_ignored", i), 32'(ign), 32'(vt[i].ei));
    end
    down = 1'b0; up = 1'b0; auto = 1'b0; hold = '0;

    // Mid-frame down request, idle 5 cycles later, hold 10, auto restore.
    tx_data = 16'hDEAD; tx_k = 2'b00;
    req_down(1'b1, 4'd10);
    for (int i = 0; i < 4; i++) begin
      tx_data = 16'hD000 + 16'(i); tick();
    end
    set_idle();
    n_low = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!link_up) n_low++;
    end
    chk("hold10_low_cycles", 32'(n_low), 32'd12);
    chk("hold10_down_cnt", 32'(down_cnt), 32'd2);
    chk("hold10_link_back", 32'(link_up), 32'd1);

    // Drain timeout without any idle word.
    tx_data = 16'hCAFE; tx_k = 2'b00;
    req_down(1'b1, 4'd0);
    n_drain = (link_up && busy) ? 1 : 0;
    n_tmo = 0; first_d = 16'h0; first_k = 2'b00;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (link_up && busy) n_drain++;
      if (tmo) begin n_tmo++; first_d = rx_data; first_k = rx_k; end
    end
    chk("tmo_drain_cycles", 32'(n_drain), 32'(TMO));
    chk("tmo_pulses", 32'(n_tmo), 32'd1);
    chk("tmo_rx_data", 32'(first_d), 32'h00BC);
    chk("tmo_rx_k", 32'(first_k), 32'h1);
    chk("tmo_restore_waits", 32'(link_up), 32'd0);
    set_idle(); tick();
    chk("tmo_restored", 32'(link_up), 32'd1);

    // Manual mode, hold 0: parked until link_up_req_i.
    req_down(1'b0, 4'd0);
    n_high = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (link_up) n_high++;
    end
    chk("manual_link_stays_low", 32'(n_high), 32'd0);
    up = 1'b1; tick(); up = 1'b0;
    chk("manual_after_up_req", 32'(link_up), 32'd0);
    tick();
    chk("manual_restored", 32'(link_up), 32'd1);

    // Down request while DOWN, then both requests in WAIT_UP.
    req_down(1'b0, 4'd3);
    tick();
    down = 1'b1; tick(); down = 1'b0;
    chk("down_in_down_ignored", 32'(ign), 32'd1);
    tick();
    chk("down_in_down_pulse_end", 32'(ign), 32'd0);
    for (int i = 0; i < 6; i++) tick();
    tx_data = 16'h5555; tx_k = 2'b00;
    down = 1'b1; up = 1'b1; tick(); down = 1'b0; up = 1'b0;
    chk("both_req_ignored", 32'(ign), 32'd1);
    tick();
    chk("both_req_pulse_end", 32'(ign), 32'd0);
    chk("both_req_link_low", 32'(link_up), 32'd0);
    set_idle(); tick();
    chk("both_req_restored", 32'(link_up), 32'd1);

    // Reset while DOWN.
    req_down(1'b0, 4'd9);
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_link_up", 32'(link_up), 32'd1);
    chk("rst_down_cnt", 32'(down_cnt), 32'd0);
    chk("rst_no_ignored", 32'(ign), 32'd0);
    tx_data = 16'hBEEF; tx_k = 2'b10; tick();
    chk("rst_pass_data", 32'(rx_data), 32'hBEEF);
    chk("rst_pass_k", 32'(rx_k), 32'h2);
    chk("rst_busy", 32'(busy), 32'd0);

    // Counter saturation over 17 down/up rounds.
    for (int r = 0; r < 17; r++) begin
      set_idle();
      req_down(1'b1, 4'd0);
      for (int i = 0; i < 4; i++) tick();
      if (r == 14) chk("sat_cnt_at_15", 32'(down_cnt), 32'd15);
    end
    chk("sat_cnt_final", 32'(down_cnt), 32'd15);

    // Randomized traffic against the model.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0) begin
        tx_data = {8'($urandom), 8'hBC}; tx_k = 2'b01;
      end else begin
        tx_data = 16'($urandom); tx_k = 2'($urandom);
      end
      down = ($urandom_range(0, 15) == 0);
      up   = ($urandom_range(0, 11) == 0);
      auto = 1'($urandom);
      hold = 4'($urandom_range(0, 6));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
